fake_netlist_vec_driver: RTL and testbench
==========================================

Name: fake_netlist_vec_driver

Overview:
- Upstream stimulus stage for a MIMIC fake netlist: 397 inputs (n_0..n_396), one output (n_1832).
- Assembles one input vector from a stream of DATA_W-bit beats, drives it onto the netlist inputs and holds it stable for SETTLE cycles.
- Samples the single response bit and returns it over a valid/ready response channel, tagged with a running vector index.

Parameters:
- VEC_W, 397, netlist input vector width (vec_o[i] drives n_i).
- DATA_W, 32, input beat width.
- SETTLE, 2, cycles vec_o is held before the response is sampled; legal range 1..255.
- IDX_W, 16, vector index counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- in_valid_i  in  1  beat valid.
- in_ready_o  out  1  beat ready.
- in_data_i  in  DATA_W  beat payload.
- vec_o  out  VEC_W  vector to netlist inputs n_0..n_(VEC_W-1).
- resp_i  in  1  netlist output n_1832.
- out_valid_o  out  1  response valid.
- out_ready_i  in  1  response ready.
- out_resp_o  out  1  sampled response bit.
- out_idx_o  out  IDX_W  index of the vector that produced out_resp_o.
- sig_o  out  32  response signature (see Optional Feature).

Behaviour:
- Clocking and reset: single clock clk_i; rst_ni is synchronous, active-low.
- Reset values: state=LOAD, beat count=0, shadow=0, vec_o=0, in_ready_o=1, out_valid_o=0, out_resp_o=0, out_idx_o=0, sig_o=0.
- BEATS = ceil(VEC_W/DATA_W); with the defaults this is 13.
- Beat k writes shadow bits [k*DATA_W +: DATA_W], truncated at VEC_W-1. Excess bits of the last beat are ignored (defaults: only in_data_i[12:0] of beat 12 is used).
- A transfer occurs when in_valid_i && in_ready_o at a rising edge.
- State LOAD:
  - in_ready_o=1; each transfer stores the beat and increments the beat count.
  - On the transfer of beat BEATS-1: vec_o<=complete shadow (including the current beat), beat count<=0, settle counter<=0, go to APPLY.
  - vec_o changes only at this edge, so netlist inputs never see a partial vector.
- State APPLY:
  - in_ready_o=0; settle counter increments each cycle.
  - At the edge where counter==SETTLE-1: out_resp_o<=resp_i, out_valid_o<=1, go to RESP.
  - Timing: last beat accepted at edge T gives vec_o valid after T, sample at edge T+SETTLE, out_valid_o high after T+SETTLE.
- State RESP:
  - in_ready_o=0; out_valid_o, out_resp_o and out_idx_o are held stable until out_ready_i.
  - On out_valid_o && out_ready_i: out_valid_o<=0, out_idx_o<=out_idx_o+1 (wraps modulo 2^IDX_W), go to LOAD.
  - No overlap: the next vector's first beat is accepted at the earliest in the cycle after the handshake.
- vec_o holds the last applied vector through RESP and the following LOAD, until the next vector completes.
- in_valid_i while in_ready_o=0: ignored, no data lost (the sender holds per valid/ready).
- out_ready_i high with out_valid_o low: no effect.
- Reset mid-operation (any state): partial vector discarded, all state returns to reset values within the same edge.

Optional Feature:
- Macro: FAKE_NETLIST_SIG_EN.
- Defined: sig_o is a 32-bit MISR updated at each response sample edge: sig <= {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ {31'b0, resp_i}.
- Not defined: sig_o is tied to 0 and no MISR logic is built.

Decomposition:
- Package fake_netlist_pkg:
  - VEC_W_DEFAULT=397 and DATA_W_DEFAULT=32.
  - state enum {LOAD, APPLY, RESP}.
  - MISR_POLY=32'h04C11DB7.
  - function beats(vec_w, data_w).
- One sub-module: fake_netlist_misr (32-bit MISR with enable and serial input), instantiated only under FAKE_NETLIST_SIG_EN.

Test Plan:
- Reset, then 13 beats of 32'hFFFFFFFF with in_valid_i held high -> in_ready_o high for 13 consecutive cycles; vec_o = all 397 ones; vec_o stays 0 before the 13th beat.
- Beats with beat k = k+1, resp_i tied 1, out_ready_i=1 -> vec_o[31:0]=1, vec_o[63:32]=2, vec_o[396:384]=13'd13; out_valid_o rises exactly 2 cycles after the last beat; out_resp_o=1; out_idx_o=0, then 1 after the handshake.
- out_ready_i held 0 for 10 cycles while in_valid_i=1 -> out_valid_o and out_resp_o stable; in_ready_o=0; no beats consumed; vec_o unchanged.
- rst_ni low for 1 cycle after 5 beats -> next 13 beats form a fresh vector; earlier data absent; out_idx_o=0.
- IDX_W=2, 5 vectors -> out_idx_o sequence 0,1,2,3,0.
- FAKE_NETLIST_SIG_EN defined, responses 1,0,1 -> sig_o = 1, then 2, then 5; without the macro sig_o=0 throughout.

Source files
------------

// File: rtl/fake_netlist_pkg.sv
// Shared types and constants for the fake-netlist vector driver.
package fake_netlist_pkg;

    localparam int VEC_W_DEFAULT  = 397;
    localparam int DATA_W_DEFAULT = 32;

    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        LOAD,
        APPLY,
        RESP
    } state_t;

    // Number of DATA_W beats needed to cover a VEC_W vector (ceiling division).
    function automatic int beats(input int vec_w, input int data_w);
        return (vec_w + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/fake_netlist_misr.sv
// 32-bit response signature register with enable and serial input.
// Only compiled when FAKE_NETLIST_SIG_EN is defined.
`ifdef FAKE_NETLIST_SIG_EN
module fake_netlist_misr
    import fake_netlist_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        din_i,
    output logic [31:0] sig_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sig_o <= '0;
        end else if (en_i) begin
            sig_o <= {sig_o[30:0], 1'b0} ^ (sig_o[31] ? MISR_POLY : 32'h0) ^ {31'b0, din_i};
        end
    end

endmodule
`endif

// File: rtl/fake_netlist_vec_driver.sv
// Assembles beat-streamed vectors, drives them onto a fake netlist, returns the sampled response.
// Optional response signature (sig_o) is built only when FAKE_NETLIST_SIG_EN is defined.
module fake_netlist_vec_driver
    import fake_netlist_pkg::*;
#(
    parameter int VEC_W  = VEC_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int SETTLE = 2,
    parameter int IDX_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic [VEC_W-1:0]  vec_o,
    input  logic              resp_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_resp_o,
    output logic [IDX_W-1:0]  out_idx_o,
    output logic [31:0]       sig_o
);

    localparam int BEATS  = beats(VEC_W, DATA_W);
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BCNT_W-1:0] LAST_BEAT   = BCNT_W'(BEATS - 1);
    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE - 1);

    state_t             state;
    logic [BCNT_W-1:0]  beat_cnt;
    logic [7:0]         settle_cnt;
    logic [VEC_W-1:0]   shadow;
    logic [VEC_W-1:0]   shadow_nxt;
    logic               xfer;
    logic               sample;

    assign xfer   = in_valid_i && in_ready_o;
    assign sample = (state == APPLY) && (settle_cnt == SETTLE_LAST);

    // Merge the current beat into the shadow; bits past VEC_W-1 in the last beat have no home.
    // NOTE: assign the default before the loop so every bit is written on every path (no latch).
    always_comb begin
        shadow_nxt = shadow;
        for (int i = 0; i < VEC_W; i++) begin
            if (beat_cnt == BCNT_W'(i / DATA_W)) begin
                shadow_nxt[i] = in_data_i[i % DATA_W];
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= LOAD;
            beat_cnt    <= '0;
            settle_cnt  <= '0;
            // NOTE: the shadow is a plain register bank, so it is cleared like any other state.
            shadow      <= '0;
            vec_o       <= '0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            out_resp_o  <= 1'b0;
            out_idx_o   <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (xfer) begin
                        shadow <= shadow_nxt;
                        if (beat_cnt == LAST_BEAT) begin
                            // Netlist inputs only ever change here, with a complete vector.
                            vec_o      <= shadow_nxt;
                            beat_cnt   <= '0;
                            settle_cnt <= '0;
                            in_ready_o <= 1'b0;
                            state      <= APPLY;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                APPLY: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (sample) begin
                        out_resp_o  <= resp_i;
                        out_valid_o <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (out_valid_o && out_ready_i) begin
                        out_valid_o <= 1'b0;
                        out_idx_o   <= out_idx_o + 1'b1;
                        in_ready_o  <= 1'b1;
                        state       <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

`ifdef FAKE_NETLIST_SIG_EN
    fake_netlist_misr u_misr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (sample),
        .din_i  (resp_i),
        .sig_o  (sig_o)
    );
`else
    assign sig_o = 32'h0;
`endif

endmodule

// File: tb/tb_fake_netlist_vec_driver.sv
// Scoreboard bench for fake_netlist_vec_driver: directed vectors, queued expectations, response monitor.
module tb_fake_netlist_vec_driver;
    import fake_netlist_pkg::*;

    localparam int VEC_W  = 397;
    localparam int DATA_W = 32;
    localparam int SETTLE = 2;
    localparam int IDX_W  = 2;
    localparam int BEATS  = 13;
    localparam int PAD_W  = BEATS * DATA_W;
    localparam int GUARD  = 200;

    typedef struct packed {
        logic             resp;
        logic [IDX_W-1:0] idx;
        logic [VEC_W-1:0] vec;
        logic [31:0]      sig;
    } exp_t;

    logic              clk;
    logic              rst_ni;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic [VEC_W-1:0]  vec_o;
    logic              resp_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              out_resp_o;
    logic [IDX_W-1:0]  out_idx_o;
    logic [31:0]       sig_o;

    int n_vec = 0;
    int n_err = 0;

    exp_t             sb[$];
    exp_t             mon_e;
    exp_t             last_e;
    logic [IDX_W-1:0] exp_idx  = '0;
    logic [31:0]      exp_sig  = '0;
    logic [VEC_W-1:0] prev_vec = '0;

    fake_netlist_vec_driver #(
        .VEC_W  (VEC_W),
        .DATA_W (DATA_W),
        .SETTLE (SETTLE),
        .IDX_W  (IDX_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .vec_o       (vec_o),
        .resp_i      (resp_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_resp_o  (out_resp_o),
        .out_idx_o   (out_idx_o),
        .sig_o       (sig_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out after %0d cycles", name, GUARD);
    endtask

    // Reference signature step, written out from the polynomial definition.
    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic b);
        logic [31:0] fb;
        fb = s[31] ? 32'h04C1_1DB7 : 32'h0;
        return {s[30:0], 1'b0} ^ fb ^ {31'b0, b};
    endfunction

    function automatic logic [PAD_W-1:0] make_pv(input int kind);
        logic [PAD_W-1:0]  p;
        logic [DATA_W-1:0] w;
        p = '0;
        for (int k = 0; k < BEATS; k++) begin
            case (kind)
                0:       w = 32'hFFFF_FFFF;
                1:       w = 32'(k + 1);
                2:       w = 32'hA5A5_0000 | 32'(k);
                default: w = (32'h1357_9BDF * 32'(kind)) ^ (32'(k) * 32'h0101_0101);
            endcase
            p[k*DATA_W +: DATA_W] = w;
        end
        // Junk above bit 396 in the last beat must be dropped by the DUT.
        if (kind == 1) p[12*DATA_W +: DATA_W] = 32'hABCD_000D;
        return p;
    endfunction

    // Presents one beat and returns #1 after the edge that accepts it; cycles counts edges spent.
    task automatic send_beat(input logic [DATA_W-1:0] d, inout int cycles);
        int g;
        g = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        while (!in_ready_o && g < GUARD) begin
            @(posedge clk); #1;
            g++;
            cycles++;
        end
        if (g >= GUARD) timeout("beat_accept");
        @(posedge clk); #1;
        cycles++;
    endtask

    task automatic send_vec(input logic [PAD_W-1:0] pv, input logic r, output int cycles);
        logic [VEC_W-1:0] v;
        exp_t             e;
        v      = pv[VEC_W-1:0];
        resp_i = r;
        cycles = 0;
`ifdef FAKE_NETLIST_SIG_EN
        exp_sig = misr_step(exp_sig, r);
`endif
        e.resp = r;
        e.idx  = exp_idx;
        e.vec  = v;
        e.sig  = exp_sig;
        sb.push_back(e);
        last_e  = e;
        exp_idx = exp_idx + 1'b1;
        for (int k = 0; k < BEATS - 1; k++) send_beat(pv[k*DATA_W +: DATA_W], cycles);
        check("vec_hold_before_last_beat", vec_o, prev_vec);
        send_beat(pv[(BEATS-1)*DATA_W +: DATA_W], cycles);
        in_valid_i = 1'b0;
        check("vec_applied", vec_o, v);
        prev_vec = v;
        @(posedge clk); #1;
        check("out_valid_settle_1", VEC_W'(out_valid_o), VEC_W'(1'b0));
        @(posedge clk); #1;
        check("out_valid_settle_2", VEC_W'(out_valid_o), VEC_W'(1'b1));
    endtask

    // Monitor: pops one expectation for every response handshake.
    always @(negedge clk) begin
        if (rst_ni && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_response: idx %0d with empty scoreboard", out_idx_o);
            end else begin
                mon_e = sb.pop_front();
                check("out_resp", VEC_W'(out_resp_o), VEC_W'(mon_e.resp));
                check("out_idx", VEC_W'(out_idx_o), VEC_W'(mon_e.idx));
                check("resp_vec", vec_o, mon_e.vec);
                check("sig", VEC_W'(sig_o), VEC_W'(mon_e.sig));
            end
        end
    end

    initial begin
        int cyc;
        int g;
        logic [VEC_W-1:0] ones;
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        resp_i      = 1'b0;
        out_ready_i = 1'b1;
        ones        = '1;

        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        check("rst_in_ready", VEC_W'(in_ready_o), VEC_W'(1'b1));
        check("rst_out_valid", VEC_W'(out_valid_o), VEC_W'(1'b0));
        check("rst_vec", vec_o, '0);
        check("rst_out_resp", VEC_W'(out_resp_o), VEC_W'(1'b0));
        check("rst_out_idx", VEC_W'(out_idx_o), VEC_W'(0));
        check("rst_sig", VEC_W'(sig_o), VEC_W'(0));

        // All-ones vector: 13 back-to-back beats, one per cycle.
        send_vec(make_pv(0), 1'b0, cyc);
        check("ones_ready_cycles", VEC_W'(cyc), VEC_W'(BEATS));
        check("ones_vec", vec_o, ones);

        // Counting beats with junk in the unused tail of the last beat.
        send_vec(make_pv(1), 1'b1, cyc);
        check("cnt_vec_lo", VEC_W'(vec_o[31:0]), VEC_W'(32'd1));
        check("cnt_vec_b1", VEC_W'(vec_o[63:32]), VEC_W'(32'd2));
        check("cnt_vec_tail", VEC_W'(vec_o[396:384]), VEC_W'(13'd13));

        // Back-pressure: response held, beats offered but refused.
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        send_vec(make_pv(2), 1'b1, cyc);
        in_valid_i = 1'b1;
        in_data_i  = 32'hFEED_FACE;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("hold_out_valid", VEC_W'(out_valid_o), VEC_W'(1'b1));
            check("hold_out_resp", VEC_W'(out_resp_o), VEC_W'(last_e.resp));
            check("hold_out_idx", VEC_W'(out_idx_o), VEC_W'(last_e.idx));
            check("hold_in_ready", VEC_W'(in_ready_o), VEC_W'(1'b0));
            check("hold_vec", vec_o, last_e.vec);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;

        // Partial vector then a one-cycle reset: everything starts over.
        cyc = 0;
        for (int k = 0; k < 5; k++) send_beat(32'hDEAD_BEEF, cyc);
        in_valid_i = 1'b0;
        rst_ni     = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        check("midrst_vec", vec_o, '0);
        check("midrst_in_ready", VEC_W'(in_ready_o), VEC_W'(1'b1));
        check("midrst_out_idx", VEC_W'(out_idx_o), VEC_W'(0));
        check("midrst_sig", VEC_W'(sig_o), VEC_W'(0));
        exp_idx  = '0;
        exp_sig  = '0;
        prev_vec = '0;

        // Five vectors: index wraps 0,1,2,3,0; responses 1,0,1,0,1.
        for (int n = 0; n < 5; n++) send_vec(make_pv(3 + n), ((n % 2) == 0), cyc);

        g = 0;
        while (sb.size() != 0 && g < GUARD) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= GUARD) timeout("scoreboard_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
